// File: rtl/bram_loader_pkg.sv
// Shared types and helpers for the BRAM image loader.
// The VERIFY state exists only when BRAM_IMAGE_LOADER_VERIFY_EN is defined.
package bram_loader_pkg;

`ifdef BRAM_IMAGE_LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_VERIFY,
        ST_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } state_t;
`endif

    localparam int unsigned LANES    = 4;
    localparam int unsigned ADDR_INC = 4;

    // Leading-lane write mask: lane 0 is the most significant byte.
    function automatic logic [3:0] lane_mask(input logic [2:0] bytes_filled);
        logic [3:0] m;
        case (bytes_filled)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b1000;
            3'd2:    m = 4'b1100;
            3'd3:    m = 4'b1110;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/bram_image_loader_byte_word_packer.sv
// Packs a byte stream big-endian into 32-bit words and reports which lanes
// hold data; the word is presented until the owner clears it.
module byte_word_packer
    import bram_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        last,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [3:0]  mask,
    output logic        word_valid
);

    logic [2:0] fill;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
            word <= '0;
        end else if (clear) begin
            fill <= '0;
            word <= '0;
        end else if (accept) begin
            fill <= fill + 3'd1;
            word <= word | ({byte_in, 24'h000000} >> {fill, 3'b000});
        end
    end

    assign mask       = lane_mask(fill);
    assign word_valid = accept && ((fill == 3'(LANES - 1)) || last);

endmodule

// File: rtl/bram_image_loader.sv
// Port-B master that streams a program image into MicroBlaze LMB BRAM.
// Define BRAM_IMAGE_LOADER_VERIFY_EN to add a read-back checksum pass.
module bram_image_loader
    import bram_loader_pkg::*;
#(
    parameter int unsigned C_MEMSIZE     = 'h8000,
    parameter int unsigned C_BASEADDR    = 'h0,
    parameter int          C_PORT_DWIDTH = 32,
    parameter int          C_PORT_AWIDTH = 32,
    parameter int          C_NUM_WE      = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Start,
    input  logic [31:0]              Byte_Len,
    input  logic [7:0]               S_Data,
    input  logic                     S_Valid,
    output logic                     S_Ready,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Error,
    output logic [15:0]              Words_Written,
    output logic                     BRAM_Rst_B,
    output logic                     BRAM_Clk_B,
    output logic                     BRAM_EN_B,
    output logic [C_NUM_WE-1:0]      BRAM_WEN_B,
    output logic [C_PORT_AWIDTH-1:0] BRAM_Addr_B,
    output logic [C_PORT_DWIDTH-1:0] BRAM_Dout_B,
    input  logic [C_PORT_DWIDTH-1:0] BRAM_Din_B
);

    state_t                   state, state_nxt;
    logic [C_PORT_AWIDTH-1:0] addr;
    logic [31:0]              remaining;
    logic [15:0]              words;
    logic                     error_q;

    logic        accept, clear, start_ok, len_zero, len_over;
    logic [31:0] pack_word;
    logic [3:0]  pack_mask;
    logic        word_valid;

    assign start_ok = Start && ((state == ST_IDLE) || (state == ST_DONE));
    assign len_zero = (Byte_Len == '0);
    assign len_over = (Byte_Len > C_MEMSIZE);
    assign accept   = (state == ST_FILL) && S_Valid;
    assign clear    = (state == ST_WRITE);

    byte_word_packer u_packer (
        .clk        (Clk),
        .rst        (Rst),
        .accept     (accept),
        .last       (remaining == 32'd1),
        .clear      (clear),
        .byte_in    (S_Data),
        .word       (pack_word),
        .mask       (pack_mask),
        .word_valid (word_valid)
    );

`ifdef BRAM_IMAGE_LOADER_VERIFY_EN
    logic [15:0] vcnt;
    logic [31:0] write_sum, read_sum, read_masked;
    logic [3:0]  last_mask;

    // Only the final word can be partial, so only its unwritten lanes are ignored.
    assign read_masked = BRAM_Din_B & lane_bits((vcnt == words) ? last_mask : 4'b1111);
`else
    logic unused_din;
    assign unused_din = ^BRAM_Din_B;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        BRAM_EN_B  = 1'b0;
        BRAM_WEN_B = '0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (Start) state_nxt = (len_zero || len_over) ? ST_DONE : ST_FILL;
            end
            ST_FILL: begin
                if (word_valid) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                BRAM_EN_B  = 1'b1;
                BRAM_WEN_B = pack_mask;
`ifdef BRAM_IMAGE_LOADER_VERIFY_EN
                state_nxt  = (remaining != '0) ? ST_FILL : ST_VERIFY;
`else
                state_nxt  = (remaining != '0) ? ST_FILL : ST_DONE;
`endif
            end
`ifdef BRAM_IMAGE_LOADER_VERIFY_EN
            ST_VERIFY: begin
                // One extra cycle after the last read address collects its data.
                if (vcnt != words) BRAM_EN_B = 1'b1;
                else               state_nxt = ST_DONE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            addr      <= '0;
            remaining <= '0;
            words     <= '0;
            error_q   <= 1'b0;
`ifdef BRAM_IMAGE_LOADER_VERIFY_EN
            vcnt      <= '0;
            write_sum <= '0;
            read_sum  <= '0;
            last_mask <= '0;
`endif
        end else begin
            if (start_ok) begin
                if (len_zero) begin
                    error_q <= 1'b0;
                end else if (len_over) begin
                    error_q <= 1'b1;
                end else begin
                    error_q   <= 1'b0;
                    words     <= '0;
                    addr      <= C_PORT_AWIDTH'(C_BASEADDR);
                    remaining <= Byte_Len;
`ifdef BRAM_IMAGE_LOADER_VERIFY_EN
                    write_sum <= '0;
`endif
                end
            end
            if (accept) remaining <= remaining - 32'd1;
            if (state == ST_WRITE) begin
                addr  <= addr + C_PORT_AWIDTH'(ADDR_INC);
                words <= words + 16'd1;
            end
`ifdef BRAM_IMAGE_LOADER_VERIFY_EN
            if (state == ST_WRITE) begin
                write_sum <= write_sum + pack_word;
                if (remaining == '0) begin
                    addr      <= C_PORT_AWIDTH'(C_BASEADDR);
                    last_mask <= pack_mask;
                    vcnt      <= '0;
                    read_sum  <= '0;
                end
            end
            if (state == ST_VERIFY) begin
                vcnt <= vcnt + 16'd1;
                if (vcnt != words) addr <= addr + C_PORT_AWIDTH'(ADDR_INC);
                if (vcnt != '0)    read_sum <= read_sum + read_masked;
                if ((vcnt == words) && ((read_sum + read_masked) != write_sum)) error_q <= 1'b1;
            end
`endif
        end
    end

    assign S_Ready       = (state == ST_FILL);
    assign Done          = (state == ST_DONE);
    assign Busy          = (state != ST_IDLE) && (state != ST_DONE);
    assign Error         = error_q;
    assign Words_Written = words;
    assign BRAM_Addr_B   = addr;
    assign BRAM_Dout_B   = pack_word;
    assign BRAM_Rst_B    = Rst;
    assign BRAM_Clk_B    = Clk;

endmodule

// File: tb/tb_bram_image_loader.sv
// Scoreboard bench for bram_image_loader: expected BRAM writes are queued by
// the stimulus and popped by a negedge monitor; status is checked after each load.
module tb_bram_image_loader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [31:0] Byte_Len = '0;
    logic [7:0]  S_Data = '0;
    logic        S_Valid = 1'b0;
    logic        S_Ready, Busy, Done, Error;
    logic [15:0] Words_Written;
    logic        BRAM_Rst_B, BRAM_Clk_B, BRAM_EN_B;
    logic [3:0]  BRAM_WEN_B;
    logic [31:0] BRAM_Addr_B, BRAM_Dout_B;
    logic [31:0] BRAM_Din_B = '0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wen;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          en_count = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          lat;
    int          en0;
    bit          corrupt = 1'b0;
    logic [7:0]  img [16];
    logic [31:0] mem [256];

    bram_image_loader dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Start         (Start),
        .Byte_Len      (Byte_Len),
        .S_Data        (S_Data),
        .S_Valid       (S_Valid),
        .S_Ready       (S_Ready),
        .Busy          (Busy),
        .Done          (Done),
        .Error         (Error),
        .Words_Written (Words_Written),
        .BRAM_Rst_B    (BRAM_Rst_B),
        .BRAM_Clk_B    (BRAM_Clk_B),
        .BRAM_EN_B     (BRAM_EN_B),
        .BRAM_WEN_B    (BRAM_WEN_B),
        .BRAM_Addr_B   (BRAM_Addr_B),
        .BRAM_Dout_B   (BRAM_Dout_B),
        .BRAM_Din_B    (BRAM_Din_B)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // BRAM port-B model: byte-enabled writes, 1-cycle read latency, optional corruption.
    always @(posedge Clk) begin
        if (BRAM_EN_B && BRAM_WEN_B != 4'd0) begin
            for (int k = 0; k < 4; k++)
                if (BRAM_WEN_B[3-k])
                    mem[BRAM_Addr_B[9:2]][31-8*k -: 8] <= BRAM_Dout_B[31-8*k -: 8];
        end
        if (BRAM_EN_B && BRAM_WEN_B == 4'd0)
            BRAM_Din_B <= mem[BRAM_Addr_B[9:2]] ^ (corrupt ? 32'h0000_0100 : 32'h0);
    end

    always @(negedge Clk) begin : monitor
        wr_t e;
        if (BRAM_EN_B) en_count++;
        if (BRAM_EN_B && BRAM_WEN_B != 4'd0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h wen=%b, expected no write",
                         BRAM_Addr_B, BRAM_Dout_B, BRAM_WEN_B);
            end else begin
                e = exp_q.pop_front();
                if (BRAM_Addr_B !== e.addr || BRAM_Dout_B !== e.data || BRAM_WEN_B !== e.wen) begin
                    n_bad++;
                    $display("FAIL bram_write: got addr=%h data=%h wen=%b, expected addr=%h data=%h wen=%b",
                             BRAM_Addr_B, BRAM_Dout_B, BRAM_WEN_B, e.addr, e.data, e.wen);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        exp_q.push_back(wr_t'{addr: a, data: d, wen: w});
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_s_ready"}, 32'(S_Ready), 32'd0);
        check({tag, "_busy"},    32'(Busy), 32'd0);
        check({tag, "_done"},    32'(Done), 32'd0);
        check({tag, "_error"},   32'(Error), 32'd0);
        check({tag, "_en"},      32'(BRAM_EN_B), 32'd0);
        check({tag, "_wen"},     32'(BRAM_WEN_B), 32'd0);
        check({tag, "_addr"},    BRAM_Addr_B, 32'd0);
        check({tag, "_dout"},    BRAM_Dout_B, 32'd0);
        check({tag, "_words"},   32'(Words_Written), 32'd0);
        check({tag, "_bram_rst"}, 32'(BRAM_Rst_B), 32'd1);
    endtask

    // Pulses Start, then offers img[0..n_feed-1]; optional random stalls and one stray Start.
    task automatic run_load(input int len, input int n_feed, input bit stall, input int glitch_at);
        int idx = 0;
        int guard = 0;
        bit hs;
        Start = 1'b1;
        Byte_Len = 32'(len);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        t_start = cyc;
        while (idx < n_feed && guard < 400) begin
            S_Valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            S_Data  = S_Valid ? img[idx] : 8'($urandom);
            Start   = (guard == glitch_at);
            if (guard == glitch_at) Byte_Len = 32'd0;
            @(negedge Clk);
            hs = S_Valid && S_Ready;
            @(posedge Clk);
            #1;
            if (hs) idx++;
            guard++;
        end
        S_Valid = 1'b0;
        Start = 1'b0;
        if (idx < n_feed) begin
            n_cmp++;
            n_bad++;
            $display("FAIL feed_timeout: got %0d bytes accepted, expected %0d", idx, n_feed);
        end
    endtask

    task automatic wait_done(output int latency);
        int g = 0;
        @(negedge Clk);
        while (!Done && g < 1000) begin
            @(negedge Clk);
            g++;
        end
        if (!Done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got Done=0 after %0d cycles, expected Done=1", g);
        end
        latency = cyc - t_start;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no summary, expected bench completion");
        $fatal(1, "bench stalled");
    end

    initial begin
        #12;
        check_quiet("por");
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        // Two full words.
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        expect_write(32'h0, 32'h0102_0304, 4'b1111);
        expect_write(32'h4, 32'h0506_0708, 4'b1111);
        run_load(8, 8, 1'b0, -1);
        wait_done(lat);
        check("t8_done", 32'(Done), 32'd1);
        check("t8_error", 32'(Error), 32'd0);
        check("t8_words", 32'(Words_Written), 32'd2);
        check("t8_busy", 32'(Busy), 32'd0);

        // Partial final word.
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
        img[3] = 8'hDD; img[4] = 8'hEE; img[5] = 8'hFF;
        expect_write(32'h0, 32'hAABB_CCDD, 4'b1111);
        expect_write(32'h4, 32'hEEFF_0000, 4'b1100);
        run_load(6, 6, 1'b0, -1);
        wait_done(lat);
        check("t6_words", 32'(Words_Written), 32'd2);
        check("t6_error", 32'(Error), 32'd0);

        // Zero length: immediate Done, no port activity.
        en0 = en_count;
        run_load(0, 0, 1'b0, -1);
        wait_done(lat);
        check("zero_latency", 32'(lat), 32'd0);
        check("zero_error", 32'(Error), 32'd0);
        check("zero_no_en", 32'(en_count - en0), 32'd0);

        // Oversize image.
        en0 = en_count;
        run_load('h8001, 0, 1'b0, -1);
        wait_done(lat);
        check("over_latency", 32'(lat), 32'd0);
        check("over_done", 32'(Done), 32'd1);
        check("over_error", 32'(Error), 32'd1);
        check("over_no_en", 32'(en_count - en0), 32'd0);

        // Random stalls with a stray Start mid-load.
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        expect_write(32'h0, 32'h0102_0304, 4'b1111);
        expect_write(32'h4, 32'h0506_0708, 4'b1111);
        run_load(8, 8, 1'b1, 3);
        wait_done(lat);
        check("stall_words", 32'(Words_Written), 32'd2);
        check("stall_error", 32'(Error), 32'd0);

        // Single word; Done latency reflects the optional verify pass.
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        expect_write(32'h0, 32'h1122_3344, 4'b1111);
        run_load(4, 4, 1'b0, -1);
        wait_done(lat);
`ifdef BRAM_IMAGE_LOADER_VERIFY_EN
        check("w4_latency", 32'(lat), 32'd7);
`else
        check("w4_latency", 32'(lat), 32'd5);
`endif
        check("w4_error", 32'(Error), 32'd0);
        check("w4_words", 32'(Words_Written), 32'd1);

`ifdef BRAM_IMAGE_LOADER_VERIFY_EN
        corrupt = 1'b1;
        expect_write(32'h0, 32'h1122_3344, 4'b1111);
        run_load(4, 4, 1'b0, -1);
        wait_done(lat);
        check("verify_corrupt_error", 32'(Error), 32'd1);
        corrupt = 1'b0;
`endif

        // Reset after five bytes of a 16-byte image.
        for (int i = 0; i < 16; i++) img[i] = 8'(8'h10 + i);
        expect_write(32'h0, 32'h1011_1213, 4'b1111);
        run_load(16, 5, 1'b0, -1);
        #2;
        Rst = 1'b1;
        #1;
        check_quiet("mid_rst");
        check("mid_rst_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("post_rst_idle_busy", 32'(Busy), 32'd0);

        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        expect_write(32'h0, 32'h0102_0304, 4'b1111);
        expect_write(32'h4, 32'h0506_0708, 4'b1111);
        run_load(8, 8, 1'b0, -1);
        wait_done(lat);
        check("reload_words", 32'(Words_Written), 32'd2);
        check("reload_error", 32'(Error), 32'd0);

        repeat (4) @(posedge Clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_image_loader.md
Name: bram_image_loader

Overview:
- Port-B master for the MicroBlaze local-memory BRAM block (dual-port, 32 KB, 32-bit, 4 byte-write-enables).
- Accepts a byte stream from the SPI flash reader, packs it big-endian into 32-bit words, and writes the program image into BRAM through port B before the processor is released.
- The BRAM's port A remains owned by the processor's LMB controller.

Parameters:
- C_MEMSIZE, 'h8000, BRAM size in bytes; power of two.
- C_BASEADDR, 'h00000000, byte address of the first word written; word aligned.
- C_PORT_DWIDTH, 32, BRAM data width; fixed at 32.
- C_PORT_AWIDTH, 32, BRAM address width.
- C_NUM_WE, 4, byte write enables; fixed at 4.

Ports:
- Clk  in  1  system clock
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle pulse; begins a load, honoured in IDLE/DONE only
- Byte_Len  in  [0:31]  image length in bytes, sampled on Start
- S_Data  in  [0:7]  stream byte
- S_Valid  in  1  S_Data valid
- S_Ready  out  1  byte accepted when S_Valid & S_Ready
- Busy  out  1  load in progress
- Done  out  1  level; high from completion until the next accepted Start
- Error  out  1  level; valid while Done is high
- Words_Written  out  [0:15]  count of BRAM write cycles issued
- BRAM_Rst_B  out  1  = Rst
- BRAM_Clk_B  out  1  = Clk
- BRAM_EN_B  out  1  port enable
- BRAM_WEN_B  out  [0:3]  byte write enables; bit 0 corresponds to bits [0:7]
- BRAM_Addr_B  out  [0:31]  byte address
- BRAM_Dout_B  out  [0:31]  write data to BRAM
- BRAM_Din_B  in  [0:31]  read data from BRAM

Behaviour:
- Reset values (asynchronous, while Rst high): state IDLE; S_Ready, Busy, Done, Error, BRAM_EN_B = 0; BRAM_WEN_B = 0; Addr, Dout, Words_Written, byte lane, pack register = 0.
- Reset mid-load abandons the load immediately; no further writes are issued.
- States: IDLE, FILL, WRITE, VERIFY (optional), DONE.
- IDLE/DONE + Start:
  - Byte_Len == 0 -> DONE, Error=0, no writes.
  - Byte_Len > C_MEMSIZE -> DONE, Error=1, no writes.
  - Otherwise -> FILL; clear Done, Error and Words_Written; address = C_BASEADDR; set Busy.
- Start in any other state is ignored.
- FILL: S_Ready=1.
  - Each accepted byte goes to lane k (k=0..3, lane 0 = bits [0:7], big-endian); remaining-byte counter decrements.
  - When lane 3 is filled, or the last image byte is accepted -> WRITE.
- WRITE: exactly one cycle.
  - S_Ready=0, EN=1.
  - WEN = mask of filled lanes: 4'b1111 for full words; a partial final word enables only its leading lanes, e.g. 2 bytes -> 4'b1100.
  - Dout = pack register, with unfilled lanes 0.
  - Addr = current address; then address += 4 and Words_Written += 1.
  - Next state: FILL if bytes remain, else VERIFY or DONE.
- Throughput: at most 4 bytes per 5 cycles. Write latency: BRAM write occurs the cycle after the 4th byte handshake.
- BRAM_EN_B and BRAM_WEN_B are zero outside WRITE/VERIFY.
- Address never wraps; the length check guarantees last address < C_BASEADDR + C_MEMSIZE.
- S_Valid held with S_Ready low transfers nothing. Bytes presented in IDLE/DONE are not accepted.
- DONE: Busy=0, Done=1, stays until the next Start.

Optional Feature:
- Macro: BRAM_IMAGE_LOADER_VERIFY_EN.
- Defined: after the last write, enter VERIFY.
  - Replay every written address with EN=1, WEN=0.
  - BRAM read latency is 1 cycle; compare BRAM_Din_B on the following cycle against the word recomputed from a running copy, masked by the lanes that were written.
  - Words are stored in a 2-word-deep shadow only as needed. The verifier re-reads and compares against a CRC-free sum: a 32-bit additive checksum of written words vs. the checksum of read words.
  - Any mismatch -> Error=1.
  - Adds (words+1) cycles before DONE.
- Undefined: no VERIFY state and no read traffic. DONE follows the final WRITE; Error only reflects the length check.

Decomposition:
- Package bram_loader_pkg holds:
  - the state enum;
  - the lane-mask function (bytes_filled -> WEN);
  - constants for lane count (4) and the address increment (4).
- One sub-module is natural: byte_word_packer. It contains the byte lane counter, pack register and mask generation, and emits word, mask and word_valid to the FSM.

Test Plan:
- Byte_Len=8, bytes 01..08 -> two writes: Addr 0x0 Dout 0x01020304 WEN 1111; Addr 0x4 Dout 0x05060708 WEN 1111. Done=1, Error=0, Words_Written=2.
- Byte_Len=6, bytes AA BB CC DD EE FF -> second write Addr 0x4, Dout 0xEEFF0000, WEN 1100.
- Byte_Len=0 -> Done the next cycle, no EN pulse. Byte_Len=0x8001 -> Done=1, Error=1, no writes.
- S_Valid toggled randomly; Start pulsed mid-load -> data and addresses identical to the unstalled run; Start ignored.
- Rst asserted after 5 bytes of a 16-byte load -> all outputs zero asynchronously. A subsequent Start reloads from Addr C_BASEADDR.
- VERIFY_EN defined, Byte_Len=4: the BRAM model corrupts the readback -> Error=1. With the clean model, Error=0 and Done is 2 cycles later than without the macro.
